// File: rtl/if_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {pc, instr} pairs with valid/ready handshakes on both sides and a flush.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module if_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pre_valid,
  output logic                   o_pre_ready,
  input  logic [`CPU_WIDTH-1:0]  i_pc,
  input  logic [`INS_WIDTH-1:0]  i_instr,
  output logic                   o_post_valid,
  input  logic                   i_post_ready,
  output logic [`CPU_WIDTH-1:0]  o_pc,
  output logic [`INS_WIDTH-1:0]  o_instr,
  input  logic                   i_flush,
  output logic [CNT_W-1:0]       o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [`CPU_WIDTH-1:0] pc_mem    [DEPTH];
  logic [`INS_WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  enq;
  logic                  deq;

  // Ready depends only on state, flush and reset, never on the downstream ready.
  assign o_pre_ready  = !i_rst && (count != FULL) && !i_flush;
  assign o_post_valid = (count != '0);
  assign o_pc         = pc_mem[rd_ptr];
  assign o_instr      = instr_mem[rd_ptr];
  assign o_count      = count;

  assign enq = i_pre_valid && o_pre_ready;
  assign deq = o_post_valid && i_post_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (enq) begin
      pc_mem[wr_ptr]    <= i_pc;
      instr_mem[wr_ptr] <= i_instr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue (DEPTH=2): vector table plus streaming,
// wrap-around and asynchronous reset sequences.
module tb_if_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pre_valid;
  logic        pre_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        post_valid;
  logic        post_ready;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        flush;
  logic [1:0]  count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_queue #(.DEPTH(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pre_valid  (pre_valid),
    .o_pre_ready  (pre_ready),
    .i_pc         (pc_in),
    .i_instr      (instr_in),
    .o_post_valid (post_valid),
    .i_post_ready (post_ready),
    .o_pc         (pc_out),
    .o_instr      (instr_out),
    .i_flush      (flush),
    .o_count      (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pr;
    logic        fl;
    logic        exp_rdy;
    logic        exp_pv;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  int sent;
  int recv;
  int mcount;
  int cycles;
  logic enq_m;
  logic deq_m;
  logic [31:0] exp_s;

  initial begin
    //          pv  pc            instr         pr  fl  rdy pv  exp_pc        exp_instr     cnt
    vecs[0]  = '{1, 32'h80000000, 32'h00000413, 0, 0, 1, 1, 32'h80000000, 32'h00000413, 2'd1};
    vecs[1]  = '{0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h00000000, 32'h00000000, 2'd0};
    vecs[2]  = '{1, 32'h80000004, 32'h00100093, 0, 0, 1, 1, 32'h80000004, 32'h00100093, 2'd1};
    vecs[3]  = '{1, 32'h80000008, 32'h00200113, 0, 0, 1, 1, 32'h80000004, 32'h00100093, 2'd2};
    vecs[4]  = '{1, 32'h8000000C, 32'h00300193, 0, 0, 0, 1, 32'h80000004, 32'h00100093, 2'd2};
    vecs[5]  = '{1, 32'h8000000C, 32'h00300193, 1, 0, 0, 1, 32'h80000008, 32'h00200113, 2'd1};
    vecs[6]  = '{1, 32'h8000000C, 32'h00300193, 1, 0, 1, 1, 32'h8000000C, 32'h00300193, 2'd1};
    vecs[7]  = '{1, 32'h80000010, 32'h00500293, 0, 0, 1, 1, 32'h8000000C, 32'h00300193, 2'd2};
    vecs[8]  = '{1, 32'h80000014, 32'h00600313, 0, 1, 0, 0, 32'h80000010, 32'h00500293, 2'd0};
    vecs[9]  = '{0, 32'h0,        32'h0,        1, 0, 1, 0, 32'h80000010, 32'h00500293, 2'd0};
    vecs[10] = '{1, 32'h80000018, 32'h00700393, 0, 0, 1, 1, 32'h80000018, 32'h00700393, 2'd1};

    rst = 1'b1; pre_valid = 1'b0; pc_in = '0; instr_in = '0; post_ready = 1'b0; flush = 1'b0;
    #12;
    chk("reset_post_valid", {31'b0, post_valid}, 32'd0);
    chk("reset_count",      {30'b0, count},      32'd0);
    chk("reset_pc",         pc_out,              32'd0);
    chk("reset_instr",      instr_out,           32'd0);
    chk("reset_pre_ready",  {31'b0, pre_ready},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_pre_ready", {31'b0, pre_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      pre_valid = vecs[i].pv; pc_in = vecs[i].pc; instr_in = vecs[i].instr;
      post_ready = vecs[i].pr; flush = vecs[i].fl;
      #1 chk($sformatf("v%0d_pre_ready", i), {31'b0, pre_ready}, {31'b0, vecs[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_post_valid", i), {31'b0, post_valid}, {31'b0, vecs[i].exp_pv});
      chk($sformatf("v%0d_pc", i),    pc_out,    vecs[i].exp_pc);
      chk($sformatf("v%0d_instr", i), instr_out, vecs[i].exp_instr);
      chk($sformatf("v%0d_count", i), {30'b0, count}, {30'b0, vecs[i].exp_cnt});
    end

    // Drain the entry left by the table, then stream 8 PCs with random ready.
    @(negedge clk);
    pre_valid = 1'b0; flush = 1'b0; post_ready = 1'b1;
    @(posedge clk);
    #1 chk("drain_count", {30'b0, count}, 32'd0);

    sent = 0; recv = 0; mcount = 0; cycles = 0;
    while (recv < 8 && cycles < 300) begin
      @(negedge clk);
      cycles++;
      pre_valid  = (sent < 8);
      pc_in      = 32'h80000000 + 32'(4 * sent);
      instr_in   = pc_in ^ 32'h00000013;
      post_ready = 1'($urandom_range(0, 1));
      #1;
      chk("stream_count", {30'b0, count}, 32'(mcount));
      enq_m = pre_valid && (mcount != 2);
      deq_m = post_ready && (mcount != 0);
      if (deq_m) begin
        exp_s = 32'h80000000 + 32'(4 * recv);
        chk("stream_pc",    pc_out,    exp_s);
        chk("stream_instr", instr_out, exp_s ^ 32'h00000013);
      end
      @(posedge clk);
      if (enq_m) sent++;
      if (deq_m) recv++;
      mcount = mcount + (enq_m ? 1 : 0) - (deq_m ? 1 : 0);
    end
    chk("stream_done", 32'(recv), 32'd8);

    // Fill to two entries, then assert reset between edges.
    @(negedge clk);
    pre_valid = 1'b1; post_ready = 1'b0;
    pc_in = 32'h90000000; instr_in = 32'h11111111;
    @(negedge clk);
    pc_in = 32'h90000004; instr_in = 32'h22222222;
    @(negedge clk);
    pre_valid = 1'b0;
    #1 chk("prereset_count", {30'b0, count}, 32'd2);
    chk("prereset_pc", pc_out, 32'h90000000);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_post_valid", {31'b0, post_valid}, 32'd0);
    chk("async_rst_count",      {30'b0, count},      32'd0);
    chk("async_rst_pc",         pc_out,              32'd0);
    chk("async_rst_instr",      instr_out,           32'd0);
    chk("async_rst_pre_ready",  {31'b0, pre_ready},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_rst_pre_ready", {31'b0, pre_ready}, 32'd1);
    @(posedge clk);
    #1 chk("rel_rst_post_valid", {31'b0, post_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
